// File: rtl/stack_ctrl.sv
// Stack controller for a single-port synchronous RAM.
// Pushes take two cycles (accept, write). Pops take four cycles (accept, read, wait,
// capture) because the RAM returns data one clock after the address is presented.
// Every RAM-side output comes straight from a flop.
module stack_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              error,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CountMax = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] CountOne = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWrite   = 3'd1,
    StRead    = 3'd2,
    StWait    = 3'd3,
    StCapture = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               error_q, error_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]  ram_data_q, ram_data_d;
  logic               ram_wren_q, ram_wren_d;

  logic               full_w;
  logic               empty_w;
  logic [ADDR_W:0]    count_dec;

  // Occupancy flags decoded directly from the word count.
  always_comb begin
    full_w    = (count_q == CountMax);
    empty_w   = (count_q == '0);
    count_dec = count_q - CountOne;
  end

  // Next-state, counter, RAM-port and pulse-output logic.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    error_d      = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_wren_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (push && pop) begin
          error_d = 1'b1;
        end else if (push) begin
          if (full_w) begin
            error_d = 1'b1;
          end else begin
            ram_data_d = din;
            ram_addr_d = count_q[ADDR_W-1:0];
            // Registered enable: high for exactly the WRITE cycle.
            ram_wren_d = 1'b1;
            state_d    = StWrite;
          end
        end else if (pop) begin
          if (empty_w) begin
            error_d = 1'b1;
          end else begin
            ram_addr_d = count_dec[ADDR_W-1:0];
            state_d    = StRead;
          end
        end
      end

      StWrite: begin
        count_d = count_q + CountOne;
        state_d = StIdle;
      end

      // Address is on the RAM during READ; data appears during WAIT and is
      // stable for capture in the following cycle.
      StRead: begin
        state_d = StWait;
      end

      StWait: begin
        state_d = StCapture;
      end

      StCapture: begin
        dout_d       = ram_q;
        dout_valid_d = 1'b1;
        count_d      = count_dec;
        state_d      = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset clears everything at once, including the
  // write enable of an in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      error_q      <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_wren_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      error_q      <= error_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_wren_q   <= ram_wren_d;
    end
  end

  // Output wiring.
  always_comb begin
    dout       = dout_q;
    dout_valid = dout_valid_q;
    busy       = (state_q != StIdle);
    count      = count_q;
    full       = full_w;
    empty      = empty_w;
    error      = error_q;
    ram_addr   = ram_addr_q;
    ram_data   = ram_data_q;
    ram_wren   = ram_wren_q;
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a synchronous-read RAM model.
module tb_stack_ctrl;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          error;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .error      (error),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q)
  );

  always #5 clk = ~clk;

  // Single-port RAM model, read data one clock after the address.
  logic [DW-1:0] mem [2**AW];
  int wr_total = 0;
  int wr_addr0 = 0;
  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_addr] <= ram_data;
      wr_total      <= wr_total + 1;
      if (ram_addr == '0) wr_addr0 <= wr_addr0 + 1;
    end
    ram_q <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    int         cnt;
    logic       busy;
    logic       wren;
    logic       dv;
    logic       err;
    logic [7:0] dout;
    logic [4:0] addr;
  } vec_t;

  vec_t vecs [21];

  initial begin
    int snap_total;
    int snap_addr0;

    // push, pop, din, count, busy, wren, dout_valid, error, dout, ram_addr
    vecs[0]  = '{1'b1, 1'b0, 8'h12, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
    vecs[2]  = '{1'b1, 1'b0, 8'h77, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1};
    vecs[4]  = '{1'b1, 1'b0, 8'h69, 2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd2};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd2};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd2};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd2};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd2};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h69, 5'd2};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h69, 5'd1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h69, 5'd1};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h69, 5'd1};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 5'd1};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 5'd0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 5'd0};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 5'd0};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 5'd0};
    vecs[18] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 5'd0};
    vecs[19] = '{1'b1, 1'b1, 8'hAA, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 5'd0};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 5'd0};

    // Reset state
    step();
    step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dv", dout_valid, 0);
    chk("rst_err", error, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", ram_data, 0);
    rst = 1'b0;

    // Table: three pushes, three pops, pop at empty, push+pop together
    snap_total = wr_total;
    for (int i = 0; i < 21; i++) begin
      push = vecs[i].push;
      pop  = vecs[i].pop;
      din  = vecs[i].din;
      step();
      chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d_wren", i), ram_wren, vecs[i].wren);
      chk($sformatf("v%0d_dv", i), dout_valid, vecs[i].dv);
      chk($sformatf("v%0d_err", i), error, vecs[i].err);
      chk($sformatf("v%0d_dout", i), dout, vecs[i].dout);
      chk($sformatf("v%0d_addr", i), ram_addr, vecs[i].addr);
      chk($sformatf("v%0d_empty", i), empty, vecs[i].cnt == 0);
      chk($sformatf("v%0d_full", i), full, vecs[i].cnt == 32);
    end
    push = 1'b0;
    pop  = 1'b0;
    chk("tbl_writes", wr_total - snap_total, 3);
    chk("mem0", mem[0], 8'h12);
    chk("mem1", mem[1], 8'h77);
    chk("mem2", mem[2], 8'h69);

    // Reset asserted asynchronously in the WRITE cycle
    push = 1'b1;
    din  = 8'h5A;
    step();
    chk("rw_wren_pre", ram_wren, 1);
    #2 rst = 1'b1;
    #1;
    chk("rw_wren", ram_wren, 0);
    chk("rw_busy", busy, 0);
    chk("rw_count", count, 0);
    push = 1'b0;
    step();
    rst = 1'b0;
    // First edge after release accepts a request
    push = 1'b1;
    din  = 8'h3C;
    step();
    chk("post_rst_wren", ram_wren, 1);
    chk("post_rst_addr", ram_addr, 0);
    push = 1'b0;
    step();
    chk("post_rst_count", count, 1);

    // Reset asserted asynchronously in the WAIT cycle of a pop
    pop = 1'b1;
    step();
    pop = 1'b0;
    step();
    chk("rwait_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rwait_busy", busy, 0);
    chk("rwait_count", count, 0);
    chk("rwait_dv", dout_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) rst = 1'b0;
      chk($sformatf("rwait_nodv%0d", i), dout_valid, 0);
      chk($sformatf("rwait_cnt%0d", i), count, 0);
    end

    // Fill from empty: 32 pushes accepted
    snap_addr0 = wr_addr0;
    for (int i = 0; i < 32; i++) begin
      push = 1'b1;
      din  = 8'(i + 1);
      step();
      push = 1'b0;
      chk($sformatf("fill%0d_addr", i), ram_addr, i);
      chk($sformatf("fill%0d_wren", i), ram_wren, 1);
      step();
    end
    chk("fill_count", count, 32);
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);

    // 33rd push rejected without touching the RAM
    snap_total = wr_total;
    push = 1'b1;
    din  = 8'hEE;
    step();
    push = 1'b0;
    chk("ovf_err", error, 1);
    chk("ovf_wren", ram_wren, 0);
    chk("ovf_busy", busy, 0);
    step();
    chk("ovf_err_pulse", error, 0);
    chk("ovf_count", count, 32);
    chk("ovf_writes", wr_total - snap_total, 0);
    chk("ovf_addr0_writes", wr_addr0 - snap_addr0, 1);
    chk("ovf_mem0", mem[0], 8'h01);

    // push and pop together with a non-empty stack
    push = 1'b1;
    pop  = 1'b1;
    step();
    push = 1'b0;
    pop  = 1'b0;
    chk("both_err", error, 1);
    chk("both_busy", busy, 0);
    chk("both_count", count, 32);

    // Pop from full with push held throughout; push taken on the first idle cycle
    pop = 1'b1;
    step();
    pop  = 1'b0;
    push = 1'b1;
    din  = 8'hAB;
    chk("hold_read_addr", ram_addr, 31);
    chk("hold_read_busy", busy, 1);
    step();
    chk("hold_wait_err", error, 0);
    step();
    chk("hold_cap_err", error, 0);
    chk("hold_cap_wren", ram_wren, 0);
    step();
    chk("hold_dv", dout_valid, 1);
    chk("hold_dout", dout, 8'h20);
    chk("hold_count", count, 31);
    chk("hold_err", error, 0);
    chk("hold_idle", busy, 0);
    step();
    push = 1'b0;
    chk("hold_wren", ram_wren, 1);
    chk("hold_waddr", ram_addr, 31);
    chk("hold_wdata", ram_data, 8'hAB);
    step();
    chk("hold_count2", count, 32);
    chk("hold_full", full, 1);
    chk("hold_mem31", mem[31], 8'hAB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected the test to finish");
    $fatal(1, "watchdog");
  end

endmodule
